// File: rtl/acc_cmd_driver_if.sv
// Command handshake bundle between a control FSM (master) and acc_cmd_driver (slave).
// Latency: none, plain wires.
// Backpressure: the master holds cmd_valid and operands until it sees cmd_ready at a rising edge.
interface acc_cmd_driver_if #(
  parameter int DATA_WIDTH = 8,
  parameter int ATTR_WIDTH = 4
);
  logic                  cmd_valid;
  logic                  cmd_ready;
  logic [DATA_WIDTH-1:0] cmd_a;
  logic [DATA_WIDTH-1:0] cmd_b;
  logic                  cmd_sub;
  logic [ATTR_WIDTH-1:0] cmd_attr;

  modport master (
    output cmd_valid, cmd_a, cmd_b, cmd_sub, cmd_attr,
    input  cmd_ready
  );

  modport slave (
    input  cmd_valid, cmd_a, cmd_b, cmd_sub, cmd_attr,
    output cmd_ready
  );
endinterface

// File: rtl/acc_cmd_driver.sv
// Replays one add/subtract command as a fixed load/init/neg/oe waveform for the bench accumulator.
// Latency: accept to ready again is CLR_CYCLES + HOLD_CYCLES + 6 cycles; every output is registered.
// Backpressure: cmd_ready is high only in IDLE; cmd_valid seen while busy is dropped, not queued.
module acc_cmd_driver #(
  parameter int DATA_WIDTH  = 8,
  parameter int ATTR_WIDTH  = 4,
  parameter int CLR_CYCLES  = 2,
  parameter int HOLD_CYCLES = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  acc_cmd_driver_if.slave       cmd,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic [ATTR_WIDTH-1:0] attr_out,
  output logic                  signal_load,
  output logic                  signal_init,
  output logic                  signal_neg,
  output logic                  signal_oe,
  output logic                  busy,
  output logic                  done
);

  // One down-counter serves both CLR and HOLD, so size it for the longer phase.
  localparam int MAX_CYCLES = (CLR_CYCLES > HOLD_CYCLES) ? CLR_CYCLES : HOLD_CYCLES;
  localparam int CNT_W      = (MAX_CYCLES > 1) ? $clog2(MAX_CYCLES + 1) : 1;
  localparam logic [CNT_W-1:0] CLR_LOAD  = CNT_W'(CLR_CYCLES - 1);
  localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLD_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLR,
    S_GAP,
    S_LOAD_A,
    S_SEP,
    S_LOAD_B,
    S_HOLD,
    S_DONE
  } state_t;

  state_t                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] a_q, b_q;
  logic                  sub_q;
  logic [ATTR_WIDTH-1:0] attr_q;
  logic                  ready_q;
  logic                  accept;

  // Next-cycle output values, decoded from the next state and registered below.
  logic                  load_d, init_d, neg_d;
  logic [DATA_WIDTH-1:0] data_d;
  logic [ATTR_WIDTH-1:0] attr_d;

  assign cmd.cmd_ready = ready_q;
  assign accept        = cmd.cmd_valid & ready_q;

  // Next-state sequencing: fixed order, CLR and HOLD timed by the shared counter.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          state_d = S_CLR;
          cnt_d   = CLR_LOAD;
        end
      end
      S_CLR: begin
        if (cnt_q == '0) state_d = S_GAP;
        else             cnt_d   = cnt_q - CNT_W'(1);
      end
      S_GAP:    state_d = S_LOAD_A;
      S_LOAD_A: state_d = S_SEP;
      S_SEP:    state_d = S_LOAD_B;
      S_LOAD_B: begin
        state_d = S_HOLD;
        cnt_d   = HOLD_LOAD;
      end
      S_HOLD: begin
        if (cnt_q == '0) state_d = S_DONE;
        else             cnt_d   = cnt_q - CNT_W'(1);
      end
      S_DONE:   state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // Pin values for the state being entered; neg only accompanies operand A.
  always_comb begin
    load_d = 1'b0;
    init_d = 1'b0;
    neg_d  = 1'b0;
    data_d = '0;
    attr_d = '0;
    case (state_d)
      S_CLR: begin
        load_d = 1'b1;
        init_d = 1'b1;
      end
      S_GAP: begin
        neg_d = sub_q;
      end
      S_LOAD_A: begin
        load_d = 1'b1;
        init_d = 1'b1;
        neg_d  = sub_q;
        data_d = a_q;
        attr_d = attr_q;
      end
      S_SEP, S_HOLD: begin
        load_d = 1'b1;
        data_d = b_q;
        attr_d = attr_q;
      end
      S_LOAD_B: begin
        load_d = 1'b1;
        init_d = 1'b1;
        data_d = b_q;
        attr_d = attr_q;
      end
      default: ;
    endcase
  end

  // State, counter and registered outputs; reset wins over a simultaneous command.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      ready_q     <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      signal_oe   <= 1'b0;
      signal_load <= 1'b0;
      signal_init <= 1'b0;
      signal_neg  <= 1'b0;
      data_out    <= '0;
      attr_out    <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      ready_q     <= (state_d == S_IDLE);
      busy        <= (state_d != S_IDLE);
      done        <= (state_d == S_DONE);
      signal_oe   <= 1'b1;
      signal_load <= load_d;
      signal_init <= init_d;
      signal_neg  <= neg_d;
      data_out    <= data_d;
      attr_out    <= attr_d;
    end
  end

  // Operand capture at the accept edge; later input changes are ignored.
  always_ff @(posedge clk) begin
    if (!rst && accept) begin
      a_q    <= cmd.cmd_a;
      b_q    <= cmd.cmd_b;
      sub_q  <= cmd.cmd_sub;
      attr_q <= cmd.cmd_attr;
    end
  end

endmodule

// File: doc/acc_cmd_driver.md
# acc_cmd_driver

Command-side driver for the `bench` accumulator. It accepts one two-operand command through a valid/ready handshake and replays it on the accumulator's `signal_load`/`signal_init`/`signal_neg`/`signal_oe` pins as a fixed, cycle-exact waveform:

- clear the accumulator;
- inject operand A, negated for subtraction;
- inject operand B;
- hold, then release.

It replaces hand-timed stimulus with a synthesizable sequencer that sits between a control FSM and `bench`.

## Interface
Parameters:
- DATA_WIDTH, 8, operand and data bus width
- ATTR_WIDTH, 4, attribute bus width
- CLR_CYCLES, 2, cycles the clear phase lasts (≥1)
- HOLD_CYCLES, 2, cycles `signal_load` is held after operand B (≥1)

Ports:
- clk  in  1  clock; all logic on rising edge
- rst  in  1  synchronous, active-high reset
- cmd_valid  in  1  command present
- cmd_ready  out  1  driver idle and able to accept
- cmd_a  in  DATA_WIDTH  operand A
- cmd_b  in  DATA_WIDTH  operand B
- cmd_sub  in  1  0: result = B + A; 1: result = B − A (A injected with `signal_neg`)
- cmd_attr  in  ATTR_WIDTH  attribute sent with both operands
- data_out  out  DATA_WIDTH  to `bench.data_in`
- attr_out  out  ATTR_WIDTH  to `bench.attr_in`
- signal_load, signal_init, signal_neg, signal_oe  out  1 each  to same-named `bench` pins
- busy  out  1  sequence in progress
- done  out  1  one-cycle pulse at end of sequence

## Operation
- All outputs are registered.
- Reset value of every output is 0, including `signal_oe` and `cmd_ready`.
- The cycle after reset releases, the FSM is in IDLE with `cmd_ready`=1 and `signal_oe`=1.
- Handshake: a command is accepted on a rising edge with `cmd_valid`&`cmd_ready`=1. `cmd_a`, `cmd_b`, `cmd_sub` and `cmd_attr` are captured at that edge, so later input changes have no effect. `cmd_valid` while not ready is ignored and not queued.
- `signal_oe`=1 in every state after reset.

Per-state outputs (load/init/neg, data, attr):
- IDLE: 0/0/0, data=0, attr=0, `cmd_ready`=1, `busy`=0.
- CLR (CLR_CYCLES cycles): 1/1/0, data=0, attr=0.
- GAP (1 cycle): 0/0/`sub`, data=0, attr=0.
- LOAD_A (1 cycle): 1/1/`sub`, data=A, attr=attr.
- SEP (1 cycle): 1/0/0, data=B, attr=attr.
- LOAD_B (1 cycle): 1/1/0, data=B, attr=attr.
- HOLD (HOLD_CYCLES cycles): 1/0/0, data=B, attr=attr.
- DONE (1 cycle): 0/0/0, data=0, attr=0, `done`=1.

Transitions and counters:
- Unconditional order: IDLE→CLR→GAP→LOAD_A→SEP→LOAD_B→HOLD→DONE→IDLE.
- CLR and HOLD use one shared down-counter wide enough for max(CLR_CYCLES, HOLD_CYCLES).
- `busy`=1 in every state except IDLE. `cmd_ready`=0 in every state except IDLE.
- `signal_neg` is never high while `signal_init` is high for operand B.
- No arithmetic is performed. Data is passed through at full DATA_WIDTH with no truncation or extension.

## Timing
Let the accept edge be cycle k. With C = CLR_CYCLES and H = HOLD_CYCLES:

| Phase | Cycles |
|---|---|
| CLR | k+1 … k+C |
| GAP | k+C+1 |
| LOAD_A | k+C+2 |
| SEP | k+C+3 |
| LOAD_B | k+C+4 |
| HOLD | k+C+5 … k+C+4+H |
| DONE | k+C+H+5 |
| IDLE, `cmd_ready`=1 | k+C+H+6 |

- Default command-to-ready latency is 10 cycles. Maximum throughput is one command per C+H+6 cycles.
- `cmd_valid` held high during DONE is not accepted. The earliest next accept is the first IDLE cycle.
- Reset asserted in any state: at the next edge all outputs are 0 and the FSM is in IDLE. Any partial sequence is abandoned; no `done` is produced.
- Reset and `cmd_valid` asserted together: reset wins and the command is dropped.

## Test plan
- **Add:** A=5, B=3, sub=0, defaults.
  - `signal_init` pulses exactly 3 times: clear (2 cycles), A, B.
  - `data_out` shows 0,0 → 5 → 3 on those pulses. `signal_neg` stays 0 throughout.
  - `done` occurs at k+9 and `cmd_ready` returns at k+10. `bench` accumulates 8.
- **Subtract:** A=5, B=7, sub=1.
  - `signal_neg`=1 only in GAP and LOAD_A.
  - `data_out`=5 during LOAD_A and 7 during LOAD_B. `bench` result is 2.
- **Input capture:** change `cmd_a`/`cmd_b` to 0 at k+1 and hold `cmd_valid` high through the whole sequence.
  - Waveform is identical to the add case.
  - A second accept happens at k+10, not earlier.
- **Reset abort:** assert `rst` for 1 cycle during LOAD_A.
  - Next edge: all outputs 0 and no `done`.
  - Following edge: `cmd_ready`=1 and `signal_oe`=1.
  - A fresh command then completes normally.
- **Parameter sweep:** CLR_CYCLES=1, HOLD_CYCLES=5.
  - Clear `signal_init` high for 1 cycle, `signal_load` held for 5 cycles after B.
  - Latency is 12 cycles.
- **Reset values:** all outputs 0 while `rst`=1.
  - `cmd_valid` pulsed during reset is never accepted: no `busy`, no `signal_load`.
